// File: rtl/hline_zbuff_engine_p_if.sv
// AXI-master / FIFO datapath bundle between the span engine (master) and the
// memory-side fabric (slave).
interface hline_zbuff_engine_p_if;
  logic [31:0] z_fifo_in;
  logic [31:0] f_fifo_in;
  logic        axi_done;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic        axi_bus_to_z_fifo;
  logic        axi_bus_to_f_fifo;
  logic        read_in_fifos;
  logic        write_out_fifos;
  logic        read_z_out_fifo;
  logic        read_f_out_fifo;
  logic [31:0] z_out;
  logic [31:0] f_out;

  modport master (
    input  z_fifo_in, f_fifo_in, axi_done,
    output rd_req, wr_req, addr, axi_bus_to_z_fifo, axi_bus_to_f_fifo,
           read_in_fifos, write_out_fifos, read_z_out_fifo, read_f_out_fifo,
           z_out, f_out
  );

  modport slave (
    output z_fifo_in, f_fifo_in, axi_done,
    input  rd_req, wr_req, addr, axi_bus_to_z_fifo, axi_bus_to_f_fifo,
           read_in_fifos, write_out_fifos, read_z_out_fifo, read_f_out_fifo,
           z_out, f_out
  );
endinterface

// File: rtl/hline_zbuff_engine_p.sv
// Z-buffered horizontal span engine: chunked burst load of z/fb, per-pixel z
// interpolation with depth test, merged burst write-back.
module hline_zbuff_engine_p #(
  parameter int CHUNK      = 256,
  parameter int BEAT_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       fb_addr,
  input  logic [31:0]       zbuff_addr,
  input  logic [CNT_W-1:0]  dx,
  input  logic [31:0]       z1,
  input  logic [31:0]       slope,
  input  logic [31:0]       rem,
  input  logic [31:0]       err,
  input  logic [31:0]       rgbx,
  input  logic [1:0]        zfunc,
  input  logic              zwrite_en,
  hline_zbuff_engine_p_if.master bus,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              busy,
  output logic              done,
  output logic [3:0]        curr_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT   = 4'd1,
    LOOP   = 4'd2,
    LOAD_Z = 4'd3,
    LOAD_F = 4'd4,
    INTERP = 4'd5,
    WR_Z   = 4'd6,
    WR_F   = 4'd7,
    DONE   = 4'd8
  } state_t;

  localparam int              BEATS     = CHUNK / BEAT_WORDS;
  localparam logic [CNT_W-1:0] CHUNK_C  = CNT_W'(CHUNK);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0]     BEAT_BYTES = 32'(BEAT_WORDS * 4);
  localparam logic [31:0]     CHUNK_BYTES = 32'(CHUNK * 4);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] valid;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] beat;
  logic [31:0]      zsum;
  logic [31:0]      eacc;
  logic [31:0]      offset;

  logic [CNT_W-1:0] idx;
  logic             active;
  logic             live;
  logic             cmp;
  logic             pass;
  logic [31:0]      e_sum;
  logic             carry;
  logic [31:0]      step;
  logic [31:0]      base;
  logic [CNT_W-1:0] take;

  always_comb begin
    idx    = CHUNK_C - pcnt;
    active = (state == INTERP) && (pcnt != '0);
    live   = active && (idx < valid);
    unique case (zfunc)
      2'd0:    cmp = zsum <  bus.z_fifo_in;
      2'd1:    cmp = zsum <= bus.z_fifo_in;
      2'd2:    cmp = zsum >  bus.z_fifo_in;
      default: cmp = 1'b1;
    endcase
    pass  = live && cmp;
    e_sum = eacc + rem;
    carry = e_sum >= 32'(dx);
    // Bresenham carry nudges z one more unit in the slope's direction.
    step  = carry ? (slope + (slope[31] ? 32'hFFFF_FFFF : 32'd1)) : slope;
    base  = (state == LOAD_F || state == WR_F) ? fb_addr : zbuff_addr;
    take  = (remaining > CHUNK_C) ? CHUNK_C : remaining;
  end

  always_comb begin
    bus.rd_req            = (state == LOAD_Z || state == LOAD_F) && !bus.axi_done;
    bus.wr_req            = (state == WR_Z || state == WR_F) && !bus.axi_done;
    bus.addr              = base + offset + 32'(beat) * BEAT_BYTES;
    bus.axi_bus_to_z_fifo = (state == LOAD_Z);
    bus.axi_bus_to_f_fifo = (state == LOAD_F);
    bus.read_in_fifos     = active;
    bus.write_out_fifos   = active;
    bus.read_z_out_fifo   = (state == WR_Z);
    bus.read_f_out_fifo   = (state == WR_F);
    bus.z_out             = active ? ((pass && zwrite_en) ? zsum : bus.z_fifo_in) : 32'd0;
    bus.f_out             = active ? (pass ? rgbx : bus.f_fifo_in) : 32'd0;
    busy                  = (state != IDLE) && (state != DONE);
    done                  = (state == DONE);
    curr_state            = state;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      remaining <= '0;
      valid     <= '0;
      pcnt      <= '0;
      beat      <= '0;
      zsum      <= '0;
      eacc      <= '0;
      offset    <= '0;
      pass_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state <= INIT;
        INIT: begin
          remaining <= dx;
          zsum      <= z1;
          eacc      <= err;
          offset    <= '0;
          pass_cnt  <= '0;
          state     <= LOOP;
        end
        LOOP: begin
          if (remaining == '0) begin
            state <= DONE;
          end else begin
            valid     <= take;
            remaining <= remaining - take;
            pcnt      <= CHUNK_C;
            beat      <= '0;
            state     <= LOAD_Z;
          end
        end
        LOAD_Z, LOAD_F: begin
          if (bus.axi_done) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= (state == LOAD_Z) ? LOAD_F : INTERP;
            end else begin
              beat <= beat + CNT_W'(1);
            end
          end
        end
        INTERP: begin
          if (pcnt != '0) begin
            pcnt <= pcnt - CNT_W'(1);
            if (live) begin
              zsum <= zsum + step;
              eacc <= carry ? (e_sum - 32'(dx)) : e_sum;
              if (pass) pass_cnt <= pass_cnt + CNT_W'(1);
            end
          end else begin
            state <= zwrite_en ? WR_Z : WR_F;
          end
        end
        WR_Z: if (bus.axi_done) state <= WR_F;
        WR_F: begin
          if (bus.axi_done) begin
            offset <= offset + CHUNK_BYTES;
            state  <= LOOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
